// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU dispatcher and its arithmetic units.
//   - NUM_UNITS / DATA_W : unit count and operand/result width
//   - alu_op_e           : opcode, which is also the unit index
//   - ERR_*              : response error encoding
//   - disp_state_e       : dispatcher FSM states
package alu_pkg;

  localparam int unsigned NUM_UNITS = 4;
  localparam int unsigned DATA_W    = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } disp_state_e;

  // One-hot unit select for an opcode.
  function automatic logic [NUM_UNITS-1:0] op_onehot(input alu_op_e op);
    logic [NUM_UNITS-1:0] oh;
    oh     = '0;
    oh[op] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alu_dispatcher_if.sv
// Bus bundle between the instruction front end, the dispatcher and the arithmetic units.
//   cmd_*  : command valid/ready channel (opcode, operands, tag)
//   unit_* : shared operands, one-hot start, per-unit working/ack/result
//   rsp_*  : response valid/ready channel (result, tag, error)
// Modport master is the dispatcher side; slave is the front end plus units.
interface alu_dispatcher_if #(
  parameter int unsigned TAG_W = 4
);
  import alu_pkg::*;

  logic                          cmd_valid;
  logic                          cmd_ready;
  alu_op_e                       cmd_op;
  logic [DATA_W-1:0]             cmd_a;
  logic [DATA_W-1:0]             cmd_b;
  logic [TAG_W-1:0]              cmd_tag;

  logic [DATA_W-1:0]             unit_a;
  logic [DATA_W-1:0]             unit_b;
  logic [NUM_UNITS-1:0]          unit_start;
  logic [NUM_UNITS-1:0]          unit_working;
  logic [NUM_UNITS-1:0]          unit_ack;
  logic [NUM_UNITS*DATA_W-1:0]   unit_result;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_W-1:0]             rsp_data;
  logic [TAG_W-1:0]              rsp_tag;
  logic [1:0]                    rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    input  unit_working, unit_ack, unit_result,
    input  rsp_ready,
    output cmd_ready,
    output unit_a, unit_b, unit_start,
    output rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
    output unit_working, unit_ack, unit_result,
    output rsp_ready,
    input  cmd_ready,
    input  unit_a, unit_b, unit_start,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_timeout_ctr.sv
// Saturating timeout counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : restart from zero (has priority over i_en)
//   i_en       : count one cycle
//   o_tc       : count has reached TERMINAL; the counter holds there
module alu_timeout_ctr #(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned TERMINAL = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == CNT_W'(TERMINAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_dispatcher.sv
// Initiator for the adder/subtractor/multiplier/divider start/working/ack handshake.
// Takes one command at a time, starts the selected unit once it is idle, waits for its
// ack (or a timeout) and presents result, tag and error on the response channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_dispatcher_if.master (cmd_*, unit_*, rsp_* signals)
module alu_dispatcher
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic              clk,
  input logic              rst_n,
  alu_dispatcher_if.master bus
);

  disp_state_e          r_state;
  alu_op_e              r_op;
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_b;
  logic [TAG_W-1:0]     r_tag;
  logic [NUM_UNITS-1:0] r_start;
  logic                 r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_data;
  logic [TAG_W-1:0]     r_rsp_tag;
  logic [1:0]           r_rsp_err;

  logic                                w_cmd_ready;
  logic                                w_accept;
  logic                                w_div0;
  logic                                w_sel_working;
  logic                                w_sel_ack;
  logic [NUM_UNITS-1:0][DATA_W-1:0]    w_results;
  logic [DATA_W-1:0]                   w_sel_result;
  logic                                w_tc;

  assign w_cmd_ready   = (r_state == StIdle);
  assign w_accept      = bus.cmd_valid && w_cmd_ready;
  assign w_div0        = (bus.cmd_op == OP_DIV) && (bus.cmd_b == '0);

  // Only the unit selected by the registered opcode is ever looked at.
  assign w_results     = bus.unit_result;
  assign w_sel_working = bus.unit_working[r_op];
  assign w_sel_ack     = bus.unit_ack[r_op];
  assign w_sel_result  = w_results[r_op];

  // Held clear throughout ISSUE so WAIT always starts counting from zero.
  alu_timeout_ctr #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == StIssue),
    .i_en  ((r_state == StWait) && !w_sel_ack),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_start     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= ERR_NONE;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op  <= bus.cmd_op;
            r_a   <= bus.cmd_a;
            r_b   <= bus.cmd_b;
            r_tag <= bus.cmd_tag;
            if (w_div0) begin
              // Answer directly; no unit is started.
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_tag   <= bus.cmd_tag;
              r_rsp_err   <= ERR_DIV0;
              r_state     <= StResp;
            end else begin
              r_state <= StIssue;
            end
          end
        end

        StIssue: begin
          // No timeout here: a busy unit is waited on indefinitely.
          if (!w_sel_working) begin
            r_start <= op_onehot(r_op);
            r_state <= StWait;
          end
        end

        StWait: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (w_sel_ack) begin
            r_start     <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_sel_result;
            r_rsp_tag   <= r_tag;
            r_rsp_err   <= ERR_NONE;
            r_state     <= StResp;
          end else if (w_tc) begin
            r_start     <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_tag   <= r_tag;
            r_rsp_err   <= ERR_TIMEOUT;
            r_state     <= StResp;
          end
        end

        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end

        default: begin
          r_start     <= '0;
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.unit_a     = r_a;
  assign bus.unit_b     = r_b;
  assign bus.unit_start = r_start;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_dispatcher.sv
// Directed self-checking bench for alu_dispatcher (TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alu_dispatcher;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_dispatcher_if #(.TAG_W(4)) bus ();

  alu_dispatcher #(
    .TAG_W          (4),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = OP_ADD;
    bus.cmd_a        = '0;
    bus.cmd_b        = '0;
    bus.cmd_tag      = '0;
    bus.unit_working = '0;
    bus.unit_ack     = '0;
    bus.unit_result  = '0;
    bus.rsp_ready    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_unit_start", 64'(bus.unit_start), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", bus.rsp_data, 64'd0);
    check("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_unit_a", bus.unit_a, 64'd0);
    rst_n = 1'b1;
    tick();

    // ADD 5+7 tag 3, ack two cycles after start, then 5 cycles of backpressure
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 64'd5;
    bus.cmd_b     = 64'd7;
    bus.cmd_tag   = 4'd3;
    tick();
    bus.cmd_valid = 1'b0;
    check("add_issue_ready", 64'(bus.cmd_ready), 64'd0);
    check("add_issue_start", 64'(bus.unit_start), 64'd0);
    check("add_unit_a", bus.unit_a, 64'd5);
    check("add_unit_b", bus.unit_b, 64'd7);
    tick();
    check("add_wait1_start", 64'(bus.unit_start), 64'b0001);
    tick();
    check("add_wait2_start", 64'(bus.unit_start), 64'b0001);
    check("add_wait2_valid", 64'(bus.rsp_valid), 64'd0);
    bus.unit_ack[0]         = 1'b1;
    bus.unit_result[63:0]   = 64'd12;
    tick();
    bus.unit_ack[0] = 1'b0;
    check("add_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("add_rsp_data", bus.rsp_data, 64'd12);
    check("add_rsp_tag", 64'(bus.rsp_tag), 64'd3);
    check("add_rsp_err", 64'(bus.rsp_err), 64'(ERR_NONE));
    check("add_rsp_start", 64'(bus.unit_start), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_data", bus.rsp_data, 64'd12);
      check("bp_tag", 64'(bus.rsp_tag), 64'd3);
      check("bp_err", 64'(bus.rsp_err), 64'd0);
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("add_hs_valid", 64'(bus.rsp_valid), 64'd0);
    check("add_hs_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // DIV 100/0 tag 5: immediate divide-by-zero response, no start
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_DIV;
    bus.cmd_a     = 64'd100;
    bus.cmd_b     = 64'd0;
    bus.cmd_tag   = 4'd5;
    tick();
    bus.cmd_valid = 1'b0;
    check("div0_valid", 64'(bus.rsp_valid), 64'd1);
    check("div0_err", 64'(bus.rsp_err), 64'(ERR_DIV0));
    check("div0_data", bus.rsp_data, 64'd0);
    check("div0_tag", 64'(bus.rsp_tag), 64'd5);
    check("div0_start", 64'(bus.unit_start), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("div0_hs_valid", 64'(bus.rsp_valid), 64'd0);
    check("div0_hs_start", 64'(bus.unit_start), 64'd0);

    // MUL 2*3 tag 7 with the multiplier busy for 10 cycles after accept
    bus.unit_working[2] = 1'b1;
    bus.cmd_valid       = 1'b1;
    bus.cmd_op          = OP_MUL;
    bus.cmd_a           = 64'd2;
    bus.cmd_b           = 64'd3;
    bus.cmd_tag         = 4'd7;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("mul_busy_start", 64'(bus.unit_start), 64'd0);
    end
    bus.unit_working[2] = 1'b0;
    bus.unit_working[0] = 1'b1;  // busy non-selected unit must not matter
    tick();
    check("mul_start", 64'(bus.unit_start), 64'b0100);
    bus.unit_ack[1]          = 1'b1;  // stray ack from a non-selected unit
    bus.unit_result[127:64]  = 64'd55;
    tick();
    check("mul_stray_valid", 64'(bus.rsp_valid), 64'd0);
    check("mul_stray_start", 64'(bus.unit_start), 64'b0100);
    bus.unit_ack[2]          = 1'b1;
    bus.unit_result[191:128] = 64'd6;
    tick();
    bus.unit_ack     = '0;
    bus.unit_working = '0;
    check("mul_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("mul_rsp_data", bus.rsp_data, 64'd6);
    check("mul_rsp_tag", 64'(bus.rsp_tag), 64'd7);
    check("mul_rsp_err", 64'(bus.rsp_err), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // SUB 9-4 tag 2 with no ack: start high exactly 16 cycles, then timeout
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SUB;
    bus.cmd_a     = 64'd9;
    bus.cmd_b     = 64'd4;
    bus.cmd_tag   = 4'd2;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("sub_start_first", 64'(bus.unit_start), 64'b0010);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("sub_start_held", 64'(bus.unit_start), 64'b0010);
      check("sub_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    check("to_start", 64'(bus.unit_start), 64'd0);
    check("to_valid", 64'(bus.rsp_valid), 64'd1);
    check("to_err", 64'(bus.rsp_err), 64'(ERR_TIMEOUT));
    check("to_data", bus.rsp_data, 64'd0);
    check("to_tag", 64'(bus.rsp_tag), 64'd2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset pulse during WAIT, then ADD 1+1 tag 9 at minimum latency
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 64'd3;
    bus.cmd_b     = 64'd4;
    bus.cmd_tag   = 4'd1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("rw_start_before", 64'(bus.unit_start), 64'b0001);
    rst_n = 1'b0;
    #1;
    check("rw_start_async", 64'(bus.unit_start), 64'd0);
    check("rw_valid_async", 64'(bus.rsp_valid), 64'd0);
    check("rw_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rw_no_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 64'd1;
    bus.cmd_b     = 64'd1;
    bus.cmd_tag   = 4'd9;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("rw_add_start", 64'(bus.unit_start), 64'b0001);
    bus.unit_ack[0]       = 1'b1;
    bus.unit_result[63:0] = 64'd2;
    tick();
    bus.unit_ack[0] = 1'b0;
    check("rw_add_valid", 64'(bus.rsp_valid), 64'd1);
    check("rw_add_data", bus.rsp_data, 64'd2);
    check("rw_add_tag", 64'(bus.rsp_tag), 64'd9);
    check("rw_add_err", 64'(bus.rsp_err), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rw_final_ready", 64'(bus.cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatcher.md
Name: alu_dispatcher

Overview:
- Initiator-side counterpart of the arithmetic units (adder, subtractor, multiplier, divider) and their start/working/ack handshake.
- Accepts one command at a time (opcode, two 64-bit operands, tag) over a valid/ready interface.
- Checks the target unit is idle, drives its start, waits for its ack, and returns the captured result, tag and error flag on a valid/ready response interface.
- Sits between the instruction front end and the four arithmetic units; it replaces ad-hoc start sequencing in the testbench top.

Parameters:
- TAG_W, 4, width of the command/response tag.
- TIMEOUT_CYCLES, 1024, number of WAIT cycles without ack before the operation is aborted.
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_op  in  2  opcode: 0=ADD 1=SUB 2=MUL 3=DIV.
- cmd_a  in  64  operand a.
- cmd_b  in  64  operand b.
- cmd_tag  in  TAG_W  returned unchanged with the response.
- unit_a  out  64  operand a, shared by all units.
- unit_b  out  64  operand b, shared by all units.
- unit_start  out  4  one-hot start, index = opcode.
- unit_working  in  4  per-unit busy.
- unit_ack  in  4  per-unit result-valid, level.
- unit_result  in  256  unit n result at bits [64n+63:64n].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  64  result; 0 on error.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  2  0=ok, 1=divide by zero, 2=timeout.

Behaviour:
- Reset values: unit_start=0, unit_a=0, unit_b=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, timeout counter=0, state=IDLE. cmd_ready=1 after reset (combinational, equals state==IDLE).
- Asserting rst_n low mid-operation immediately drops unit_start and any pending response. The in-flight command is discarded, with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Accept when cmd_valid && cmd_ready.
  - Register op, a, b and tag; drive unit_a/unit_b from the registered operands.
  - If op==DIV and cmd_b==0, go to RESP with rsp_err=1 and rsp_data=0; no unit is started.
  - Otherwise go to ISSUE.
- ISSUE:
  - If unit_working[op]==0, set unit_start[op]=1 (registered), clear the timeout counter, and go to WAIT.
  - Otherwise stay in ISSUE; there is no timeout in ISSUE.
- WAIT:
  - unit_start[op] is held high. The counter increments each cycle that unit_ack[op]==0.
  - If unit_ack[op]==1 is sampled: capture unit_result[op] into rsp_data, set rsp_err=0, clear unit_start, set rsp_valid=1, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: clear unit_start, set rsp_data=0, rsp_err=2, rsp_valid=1, go to RESP.
  - If ack arrives on the same cycle as the timeout, ack wins.
- RESP:
  - rsp_* stable while rsp_valid && !rsp_ready.
  - On handshake: clear rsp_valid and go to IDLE. cmd_ready rises the following cycle; there is no same-cycle turnaround.
- Acks or working on non-selected units are ignored in all states.
- At most one unit_start bit is high at any time; unit_start is never high outside WAIT.
- Minimum latency, accept edge to rsp_valid: 3 cycles (1 in ISSUE, ack sampled on the first WAIT cycle). Divide by zero: 1 cycle.
- The result is passed through unmodified; no width or sign handling is done here.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - the rsp_err encoding constants (ERR_NONE, ERR_DIV0, ERR_TIMEOUT);
  - the FSM state typedef;
  - the NUM_UNITS=4 constant.
- One natural sub-module: alu_timeout_ctr (clear, enable, terminal-count output), reusable by other initiators.

Test Plan:
- ADD a=5 b=7 tag=3; adder model acks 2 cycles after start with result 12 -> unit_start=4'b0001 only while in WAIT; rsp_valid with rsp_data=12, rsp_tag=3, rsp_err=0.
- DIV a=100 b=0 -> no unit_start bit ever set; rsp_valid 1 cycle after accept with rsp_err=1, rsp_data=0.
- MUL with unit_working[2]=1 held for 10 cycles -> dispatcher remains in ISSUE with unit_start=0; start rises on the cycle after working drops; result 6 for a=2 b=3.
- SUB with the unit never acking, TIMEOUT_CYCLES=16 -> unit_start held for exactly 16 cycles, then drops; rsp_err=2, rsp_data=0.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_data/tag/err stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
- rst_n pulsed low during WAIT -> unit_start and rsp_valid go to 0 asynchronously; after release, a new ADD 1+1 completes normally with rsp_data=2.
